// File: rtl/layer_output_serializer_pkg.sv
// Shared types and constants for the layer output serializer and its ReLU clamp.
// Words are IEEE-754 singles, so the sign bit position is fixed.
package layer_output_serializer_pkg;

    localparam int DATA_W = 32;
    localparam int FP_SIGN_BIT = 31;
    localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/layer_output_serializer_fp_relu_clamp.sv
// Combinational ReLU on one IEEE-754 single: any word with the sign bit set
// (negatives, -0.0, negative NaN/Inf) becomes +0.0 and raises neg.
module fp_relu_clamp
    import layer_output_serializer_pkg::*;
(
    input  logic [DATA_W-1:0] word_in,
    output logic [DATA_W-1:0] word_out,
    output logic              neg
);

    assign neg      = word_in[FP_SIGN_BIT];
    assign word_out = neg ? FP_ZERO : word_in;

endmodule

// File: rtl/layer_output_serializer.sv
// Captures one layer's node outputs after a settle interval, clamps them with ReLU,
// and streams them one word per beat over a valid/ready interface.
module layer_output_serializer #(
    parameter int NUM_NODES     = 32,
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int IDX_W         = $clog2(NUM_NODES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_NODES*DATA_W-1:0] node_in,
    output logic                        busy,
    output logic                        done,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic [IDX_W-1:0]            m_index,
    output logic                        m_last,
    output logic [IDX_W:0]              neg_count
);

    import layer_output_serializer_pkg::*;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  settle_cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] word_buf [NUM_NODES];
    logic [DATA_W-1:0] clamped  [NUM_NODES];
    logic [NUM_NODES-1:0] neg_flag;
    logic [IDX_W:0]    neg_sum;

    for (genvar k = 0; k < NUM_NODES; k++) begin : g_clamp
        fp_relu_clamp u_clamp (
            .word_in  (node_in[k*DATA_W +: DATA_W]),
            .word_out (clamped[k]),
            .neg      (neg_flag[k])
        );
    end

    always_comb begin
        neg_sum = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            neg_sum = neg_sum + {{IDX_W{1'b0}}, neg_flag[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With no settle budget the capture cycle follows start directly, which keeps
    // the first beat at start+SETTLE_CYCLES+2 for every setting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
            SETTLE:  if (settle_cnt == '0) state_next = CAPTURE;
            CAPTURE: state_next = STREAM;
            STREAM:  if (m_ready && idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign idx_next = idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            idx        <= '0;
            data_q     <= '0;
            neg_count  <= '0;
        end else begin
            case (state)
                IDLE:   settle_cnt <= CNT_LOAD;
                SETTLE: settle_cnt <= settle_cnt - CNT_W'(1);
                // Word 0 bypasses the buffer so it is presented on the very next cycle.
                CAPTURE: begin
                    neg_count <= neg_sum;
                    idx       <= '0;
                    data_q    <= clamped[0];
                end
                STREAM: begin
                    if (m_ready && idx != LAST_IDX) begin
                        idx    <= idx_next;
                        data_q <= word_buf[idx_next];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            for (int k = 0; k < NUM_NODES; k++) begin
                word_buf[k] <= clamped[k];
            end
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign m_valid = (state == STREAM);
    assign m_data  = data_q;
    assign m_index = idx;
    assign m_last  = m_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_layer_output_serializer.sv
// Self-checking bench: two serializer instances (settle 4 and settle 0) driven with
// directed and random layers, checked against a queue-based ReLU reference model.
module tb_layer_output_serializer;

    localparam int N  = 32;
    localparam int W  = 32;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic           start4, start0;
    logic           m_ready;
    logic [N*W-1:0] node_in;

    logic          busy4, done4, valid4, last4;
    logic [W-1:0]  data4;
    logic [IW-1:0] index4;
    logic [IW:0]   neg4;
    logic          busy0, done0, valid0, last0;
    logic [W-1:0]  data0;
    logic [IW-1:0] index0;
    logic [IW:0]   neg0;

    bit sel;
    int vectors    = 0;
    int miscompares = 0;

    logic          o_busy, o_done, o_valid, o_last;
    logic [W-1:0]  o_data;
    logic [IW-1:0] o_index;
    logic [IW:0]   o_neg;

    assign o_busy  = sel ? busy0  : busy4;
    assign o_done  = sel ? done0  : done4;
    assign o_valid = sel ? valid0 : valid4;
    assign o_last  = sel ? last0  : last4;
    assign o_data  = sel ? data0  : data4;
    assign o_index = sel ? index0 : index4;
    assign o_neg   = sel ? neg0   : neg4;

    always #5 clk = ~clk;

    layer_output_serializer #(.NUM_NODES(N), .DATA_W(W), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start4), .node_in(node_in),
        .busy(busy4), .done(done4), .m_valid(valid4), .m_ready(m_ready),
        .m_data(data4), .m_index(index4), .m_last(last4), .neg_count(neg4)
    );

    layer_output_serializer #(.NUM_NODES(N), .DATA_W(W), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .node_in(node_in),
        .busy(busy0), .done(done0), .m_valid(valid0), .m_ready(m_ready),
        .m_data(data0), .m_index(index0), .m_last(last0), .neg_count(neg0)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"}, o_valid, 0);
        checkOutput({tag, "_busy"},  o_busy,  0);
        checkOutput({tag, "_done"},  o_done,  0);
        checkOutput({tag, "_last"},  o_last,  0);
        checkOutput({tag, "_data"},  o_data,  0);
        checkOutput({tag, "_index"}, o_index, 0);
        checkOutput({tag, "_neg"},   o_neg,   0);
    endtask

    task automatic fillRandom();
        logic [W-1:0] w;
        for (int k = 0; k < N; k++) begin
            w = $urandom;
            case ($urandom_range(0, 7))
                0: w = 32'h7F80_0000;
                1: w = 32'hFFC0_0000;
                2: w = 32'h8000_0000;
                default: ;
            endcase
            node_in[k*W +: W] = w;
        end
    endtask

    // Runs one layer through the selected instance and checks every beat.
    task automatic applyStimulus(input bit which, input int stall_at, input int stall_len,
                                 input bit rand_ready, input bit perturb, input int abort_at);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] w;
        int exp_neg, lat, beats, stalled, cyc, settle;
        bit rdy;
        sel    = which;
        settle = which ? 0 : 4;
        exp_q.delete();
        exp_neg = 0;
        for (int k = 0; k < N; k++) begin
            w = node_in[k*W +: W];
            if (w[W-1]) begin
                exp_q.push_back('0);
                exp_neg++;
            end else begin
                exp_q.push_back(w);
            end
        end
        m_ready = 1'b0;
        @(negedge clk);
        if (which) start0 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start4 = 1'b0;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 200) begin
            checkOutput("busy_settling", o_busy, 1);
            @(negedge clk);
            lat++;
        end
        checkOutput("first_valid_latency", lat, settle + 2);
        checkOutput("neg_count", o_neg, exp_neg);
        beats = 0;
        stalled = 0;
        cyc = 0;
        while (beats < N && cyc < 500) begin
            if (beats == abort_at) begin
                rst = 1'b1;
                m_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                m_ready = 1'b0;
                checkReset("abort");
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("no_done_after_abort", o_done, 0);
                    checkOutput("idle_after_abort", o_busy, 0);
                end
                return;
            end
            if (beats == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else if (rand_ready) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            m_ready = rdy;
            checkOutput("beat_valid", o_valid, 1);
            checkOutput("beat_busy", o_busy, 1);
            checkOutput($sformatf("beat%0d_data", beats), o_data, exp_q[beats]);
            checkOutput($sformatf("beat%0d_index", beats), o_index, beats);
            checkOutput($sformatf("beat%0d_last", beats), o_last, (beats == N - 1) ? 1 : 0);
            if (perturb && beats == 10) begin
                node_in = {N{32'h7FC0_0000}};
                if (which) start0 = 1'b1; else start4 = 1'b1;
            end
            @(negedge clk);
            cyc++;
            start0 = 1'b0;
            start4 = 1'b0;
            if (rdy) beats++;
        end
        m_ready = 1'b0;
        checkOutput("done_pulse", o_done, 1);
        checkOutput("valid_after_last", o_valid, 0);
        @(negedge clk);
        checkOutput("done_one_cycle", o_done, 0);
        checkOutput("idle_after_done", o_busy, 0);
        @(negedge clk);
        checkOutput("start_not_queued", o_busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0;
        start0 = 1'b0;
        m_ready = 1'b0;
        node_in = '0;
        repeat (2) @(negedge clk);
        sel = 1'b0;
        #1;
        checkReset("reset4");
        sel = 1'b1;
        #1;
        checkReset("reset0");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset during stream at beat 5");
        fillRandom();
        applyStimulus(1'b0, -1, 0, 1'b0, 1'b0, 5);

        $display("[TB] all words 1.0");
        node_in = {N{32'h3F80_0000}};
        applyStimulus(1'b0, -1, 0, 1'b0, 1'b0, -1);

        $display("[TB] alternating -2.0 / 3.0 with -0.0 at word 3");
        for (int k = 0; k < N; k++) node_in[k*W +: W] = (k % 2 == 0) ? 32'hC000_0000 : 32'h4040_0000;
        node_in[3*W +: W] = 32'h8000_0000;
        applyStimulus(1'b0, -1, 0, 1'b0, 1'b0, -1);

        $display("[TB] three-cycle stall at beat 7");
        fillRandom();
        applyStimulus(1'b0, 7, 3, 1'b0, 1'b0, -1);

        $display("[TB] node_in change and second start during stream");
        fillRandom();
        applyStimulus(1'b0, -1, 0, 1'b0, 1'b1, -1);

        $display("[TB] zero settle with +Inf on node 31");
        fillRandom();
        node_in[31*W +: W] = 32'h7F80_0000;
        applyStimulus(1'b1, -1, 0, 1'b0, 1'b0, -1);

        $display("[TB] random layers with random backpressure");
        for (int r = 0; r < 4; r++) begin
            fillRandom();
            applyStimulus(1'(r % 2), -1, 0, 1'b1, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
